// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC; the FPGA masters BCLK and DACLRC.
// A one-entry holding register feeds one stereo pair per frame; starvation repeats the last pair.
module i2s_dac_tx #(
   parameter int CLK_DIV      = 4,
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_BITS    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [SAMPLE_WIDTH-1:0] sample_left,
   input  logic [SAMPLE_WIDTH-1:0] sample_right,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    bclk,
   output logic                    daclrc,
   output logic                    dacdat,
   output logic                    frame_start,
   output logic                    underrun
);

   localparam int FW = 2 * SLOT_BITS;
   localparam int BW = $clog2(FW);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PAD = FW - SAMPLE_WIDTH;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
   localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);

   logic [DW-1:0]           r_div_cnt;
   logic                    r_bclk;
   logic [BW-1:0]           r_bit_cnt;
   logic                    r_daclrc;
   logic                    r_dacdat;
   logic                    r_frame_start;
   logic                    r_underrun;
   logic [FW-1:0]           r_frame;
   logic [SAMPLE_WIDTH-1:0] r_last_l;
   logic [SAMPLE_WIDTH-1:0] r_last_r;
   logic                    r_full;
   logic [SAMPLE_WIDTH-1:0] r_hold_l;
   logic [SAMPLE_WIDTH-1:0] r_hold_r;

   logic                    w_div_tc;
   logic                    w_fall;
   logic [BW-1:0]           w_bit_next;
   logic [BW-1:0]           w_dat_idx;
   logic                    w_dat_next;
   logic                    w_start;
   logic                    w_load;
   logic                    w_accept;
   logic [SAMPLE_WIDTH-1:0] w_src_l;
   logic [SAMPLE_WIDTH-1:0] w_src_r;
   logic [FW-1:0]           w_frame_new;

   always_comb begin
      w_div_tc   = enable && (r_div_cnt == DIV_LAST);
      w_fall     = w_div_tc && r_bclk;
      w_bit_next = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BW'(1);
      w_start    = w_fall && (w_bit_next == '0);
      w_load     = w_start && r_full;
      w_accept   = sample_valid && !r_full;

      // Slot k carries F[FW-k]; slot 0 still carries the outgoing frame's LSB (one-bit I2S delay).
      w_dat_idx  = BIT_LAST - w_bit_next + BW'(1);
      w_dat_next = (w_bit_next == '0) ? r_frame[0] : r_frame[w_dat_idx];

      w_src_l     = r_full ? r_hold_l : r_last_l;
      w_src_r     = r_full ? r_hold_r : r_last_r;
      w_frame_new = ({{PAD{1'b0}}, w_src_l} << PAD)
                  | ({{PAD{1'b0}}, w_src_r} << (SLOT_BITS - SAMPLE_WIDTH));
   end

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div_cnt     <= '0;
         r_bclk        <= 1'b0;
         r_bit_cnt     <= BIT_LAST;
         r_daclrc      <= 1'b0;
         r_dacdat      <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
         r_frame       <= '0;
         r_last_l      <= '0;
         r_last_r      <= '0;
      end else if (!enable) begin
         r_div_cnt     <= '0;
         r_bclk        <= 1'b0;
         r_bit_cnt     <= BIT_LAST;
         r_daclrc      <= 1'b0;
         r_dacdat      <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
         r_frame       <= '0;
      end else begin
         r_frame_start <= 1'b0;

         if (w_div_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
         end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
         end

         if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_daclrc  <= (w_bit_next >= SLOT_LEN);
            r_dacdat  <= w_dat_next;
         end

         if (w_start) begin
            r_frame_start <= 1'b1;
            r_frame       <= w_frame_new;
            r_last_l      <= w_src_l;
            r_last_r      <= w_src_r;
            if (!r_full) begin
               r_underrun <= 1'b1;
            end
         end
      end
   end

   // The holding register ignores enable so the producer can prefill it before the serializer runs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_full   <= 1'b0;
         r_hold_l <= '0;
         r_hold_r <= '0;
      end else if (w_accept) begin
         r_full   <= 1'b1;
         r_hold_l <= sample_left;
         r_hold_r <= sample_right;
      end else if (w_load) begin
         r_full <= 1'b0;
      end
   end

   assign sample_ready = ~r_full;
   assign bclk         = r_bclk;
   assign daclrc       = r_daclrc;
   assign dacdat       = r_dacdat;
   assign frame_start  = r_frame_start;
   assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: a frame-level model predicts each transmitted pair,
// a monitor decodes the serial stream and compares. A second small instance covers fast clocking.
module tb_i2s_dac_tx;

   localparam int CLK_DIV = 4;
   localparam int SW      = 16;
   localparam int SB      = 32;
   localparam int FW      = 2 * SB;
   localparam int BCLK_P  = 2 * CLK_DIV;
   localparam int FRAME_P = FW * BCLK_P;
   localparam int FIRST   = BCLK_P;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [SW-1:0] sample_left = '0;
   logic [SW-1:0] sample_right = '0;
   logic          sample_valid = 1'b0;
   logic          sample_ready, bclk, daclrc, dacdat, frame_start, underrun;

   logic          reset2 = 1'b1;
   logic          enable2 = 1'b0;
   logic [15:0]   l2 = '0;
   logic [15:0]   r2 = '0;
   logic          valid2 = 1'b0;
   logic          ready2, bclk2, lrc2, dat2, fs2, und2;

   always #5 clk = ~clk;

   i2s_dac_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_WIDTH(SW), .SLOT_BITS(SB)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .sample_left(sample_left), .sample_right(sample_right),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .bclk(bclk), .daclrc(daclrc), .dacdat(dacdat),
      .frame_start(frame_start), .underrun(underrun)
   );

   i2s_dac_tx #(.CLK_DIV(1), .SAMPLE_WIDTH(16), .SLOT_BITS(16)) dut2 (
      .clk(clk), .reset(reset2), .enable(enable2),
      .sample_left(l2), .sample_right(r2),
      .sample_valid(valid2), .sample_ready(ready2),
      .bclk(bclk2), .daclrc(lrc2), .dacdat(dat2),
      .frame_start(fs2), .underrun(und2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-level view of the transmitter) ----------------
   typedef struct {
      logic [SW-1:0] l;
      logic [SW-1:0] r;
   } pair_t;

   pair_t         exp_q[$];
   int            m_n = 0;        // enabled clock edges since enable rose
   logic          m_full = 1'b0;
   logic          m_und = 1'b0;
   logic          m_fs = 1'b0;
   logic [SW-1:0] m_hl = '0, m_hr = '0, m_ll = '0, m_lr = '0;

   initial begin
      logic was_full;
      pair_t p;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_n = 0; m_full = 1'b0; m_und = 1'b0; m_fs = 1'b0;
            m_hl = '0; m_hr = '0; m_ll = '0; m_lr = '0;
         end else begin
            was_full = m_full;
            m_fs = 1'b0;
            if (enable) begin
               m_n++;
               if (m_n >= FIRST && ((m_n - FIRST) % FRAME_P) == 0) begin
                  m_fs = 1'b1;
                  if (was_full) begin
                     m_ll = m_hl; m_lr = m_hr; m_full = 1'b0;
                  end else begin
                     m_und = 1'b1;
                  end
                  p.l = m_ll; p.r = m_lr;
                  exp_q.push_back(p);
               end
            end else begin
               m_n = 0;
               m_und = 1'b0;
            end
            if (sample_valid && !was_full) begin
               m_hl = sample_left; m_hr = sample_right; m_full = 1'b1;
            end
         end
      end
   end

   // ---------------- monitor: per-cycle control checks and serial frame decoding ----------------
   initial begin
      int cnt = -1;
      logic [63:0] word = '0;
      logic [63:0] exp_word;
      logic prev_bclk = 1'b0;
      pair_t p;
      forever begin
         @(negedge clk);
         check("bclk", bclk, (m_n / CLK_DIV) % 2);
         check("frame_start", frame_start, m_fs);
         check("sample_ready", sample_ready, !m_full);
         check("underrun", underrun, m_und);
         if (m_n == 0) begin
            check("idle_daclrc", daclrc, 0);
            check("idle_dacdat", dacdat, 0);
            if (cnt >= 0 && exp_q.size() > 0) void'(exp_q.pop_front());
            cnt = -1;
         end else begin
            if (frame_start) begin
               cnt = 0;
               word = '0;
            end
            if (bclk && !prev_bclk && cnt >= 0 && cnt < FW) begin
               check("daclrc_slot", daclrc, (cnt >= SB) ? 1 : 0);
               word = {word[62:0], dacdat};
               cnt++;
               if (cnt == FW) begin
                  if (exp_q.size() == 0) begin
                     check("frame_expected", 0, 1);
                  end else begin
                     p = exp_q.pop_front();
                     exp_word = (64'(p.l) << (FW - 1 - SW)) | (64'(p.r) << (SB - 1 - SW));
                     check("frame_word", word, exp_word);
                  end
                  cnt = -1;
               end
            end
         end
         prev_bclk = bclk;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_n(input int target, input string name);
      int guard = 0;
      while (m_n < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (m_n < target) check(name, m_n, target);
   endtask

   task automatic drive_random(input int cycles, input int pct);
      logic xfer;
      for (int c = 0; c < cycles; c++) begin
         xfer = sample_valid && sample_ready;
         @(negedge clk);
         if (xfer || !sample_valid) begin
            sample_valid = ($urandom_range(99) < pct);
            sample_left  = SW'($urandom);
            sample_right = SW'($urandom);
         end
      end
   endtask

   initial begin
      int t;
      #1 reset = 1'b0;
      reset2 = 1'b0;
      enable = 1'b1;

      // Reset with enable high, then release while disabled.
      repeat (3) @(negedge clk);
      check("rst_bclk", bclk, 0);
      check("rst_daclrc", daclrc, 0);
      check("rst_dacdat", dacdat, 0);
      check("rst_ready", sample_ready, 1);
      check("rst_underrun", underrun, 0);
      enable = 1'b0;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_ready", sample_ready, 1);
      check("idle_bclk", bclk, 0);

      // Prefill while disabled, then enable: first frame_start 8 clk later.
      sample_valid = 1'b1; sample_left = 16'hA5C3; sample_right = 16'h0F01;
      @(negedge clk);
      sample_valid = 1'b0;
      check("prefill_ready", sample_ready, 0);
      enable = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!frame_start && t < 40);
      check("first_fs_latency", t, 8);

      // Starve through frame 2; offer a pair exactly at the frame 3 start edge.
      wait_n(FIRST + 2 * FRAME_P - 1, "wait_f3");
      sample_valid = 1'b1; sample_left = 16'h1234; sample_right = 16'hBEEF;
      @(negedge clk);
      sample_valid = 1'b0;
      check("simul_accept_underrun", underrun, 1);
      check("simul_accept_ready", sample_ready, 0);
      wait_n(FIRST + 4 * FRAME_P + 100, "wait_f5");
      check("underrun_sticky", underrun, 1);

      // Continuous and bursty backpressure with random pairs.
      drive_random(3 * FRAME_P, 100);
      drive_random(2 * FRAME_P + 37, 40);
      sample_valid = 1'b0;
      repeat (200) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("disable_underrun", underrun, 0);
      check("disable_bclk", bclk, 0);

      enable = 1'b1;
      drive_random(2 * FRAME_P + 50, 60);
      sample_valid = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      // Fast instance: CLK_DIV=1, SLOT_BITS=16.
      reset2 = 1'b1;
      valid2 = 1'b1; l2 = 16'hFFFF; r2 = 16'hFFFF;
      @(negedge clk);
      valid2 = 1'b0;
      enable2 = 1'b1;
      @(negedge clk);
      check("f_bclk_rise", bclk2, 1);
      check("f_fs_early", fs2, 0);
      @(negedge clk);
      check("f_fs", fs2, 1);
      check("f_lrc_start", lrc2, 0);
      repeat (36) @(negedge clk);
      check("f_mid_lrc", lrc2, 1);
      check("f_mid_dat", dat2, 1);
      enable2 = 1'b0;
      @(negedge clk);
      check("f_dis_bclk", bclk2, 0);
      check("f_dis_lrc", lrc2, 0);
      check("f_dis_dat", dat2, 0);
      enable2 = 1'b1;
      @(negedge clk);
      check("f_re_fs_early", fs2, 0);
      @(negedge clk);
      check("f_re_fs", fs2, 1);
      check("f_re_lrc", lrc2, 0);
      check("f_re_underrun", und2, 1);
      valid2 = 1'b1; l2 = 16'h8001; r2 = 16'h7FFE;
      @(negedge clk);
      valid2 = 1'b0;
      check("f_push_ready", ready2, 0);
      repeat (25) @(negedge clk);
      reset2 = 1'b0;
      #1;
      check("f_rst_bclk", bclk2, 0);
      check("f_rst_lrc", lrc2, 0);
      check("f_rst_dat", dat2, 0);
      check("f_rst_ready", ready2, 1);
      check("f_rst_underrun", und2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
